mem_bus_responder: RTL and testbench

Memory-bus responder at the device end of the CPU's data-memory interface. Decodes the CPU's `MemBus_Address` and services every load and store. It contains a word-addressed data RAM and a small peripheral block:

- programmable timer with interrupt
- LED register
- seven-segment digit register
- free-running system-tick counter

It returns read data combinationally on `Device_Read_Data` so the CPU's MEM stage completes in one cycle.

---
 rtl/mem_bus_responder.sv | 126 ++++++++++++
 tb/tb_mem_bus_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Device-side responder for the CPU data-memory bus: word RAM plus timer, LED,
// seven-segment and system-tick registers, with combinational load data.
module mem_bus_responder #(
  parameter int unsigned RAM_WORDS   = 512,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  input  logic        MemRead,
  input  logic        MemWrite_origin,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  localparam int unsigned IdxW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    selTh, selTl, selTcon, selLed, selDigits, selSystick, selNone
  } regSelT;

  logic [31:0]     ram [RAM_WORDS];
  logic [IdxW-1:0] ramIdx;
  logic            ramHit;
  logic            ramWe;
  logic [29:0]     periphOffset;
  regSelT          regSel;
  logic            unusedByteLane;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic        tlStore;
  logic        tconStore;

  // Byte-lane bits carry no meaning on a word-only bus.
  assign unusedByteLane = ^MemBus_Address[1:0];

  assign ramHit       = (MemBus_Address[31:IdxW+2] == '0);
  assign ramIdx       = MemBus_Address[IdxW+1:2];
  assign periphOffset = MemBus_Address[31:2] - PERIPH_BASE[31:2];

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned (avoids a latch).
    regSel = selNone;
    if (!ramHit) begin
      case (periphOffset)
        30'd0:   regSel = selTh;
        30'd1:   regSel = selTl;
        30'd2:   regSel = selTcon;
        30'd3:   regSel = selLed;
        30'd4:   regSel = selDigits;
        30'd5:   regSel = selSystick;
        default: regSel = selNone;
      endcase
    end
  end

  // A store issued while reset is held must not reach the RAM.
  assign ramWe = MemWrite_origin & ramHit & ~reset;

  // NOTE: the RAM array has no reset; clearing a memory would force it into flops.
  always_ff @(posedge clk) begin
    if (ramWe) ram[ramIdx] <= MemBus_Write_Data;
  end

  assign tlStore   = MemWrite_origin && (regSel == selTl);
  assign tconStore = MemWrite_origin && (regSel == selTcon);

  // NOTE: every clocked register uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (MemWrite_origin && regSel == selTh)     th     <= MemBus_Write_Data;
      if (MemWrite_origin && regSel == selLed)    leds   <= MemBus_Write_Data[7:0];
      if (MemWrite_origin && regSel == selDigits) digits <= MemBus_Write_Data[11:0];

      // A CPU store to TL or TCON overrides the whole timer step for this cycle.
      if (tlStore || tconStore) begin
        if (tlStore)   tl   <= MemBus_Write_Data;
        if (tconStore) tcon <= MemBus_Write_Data[2:0];
      end else if (tcon[0]) begin
        if (tl != '1) begin
          tl <= tl + 32'd1;
        end else begin
          tl <= th;
          if (tcon[1]) tcon[2] <= 1'b1;
        end
      end
    end
  end

  assign irq = tcon[1] & tcon[2];

  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      if (ramHit) begin
        Device_Read_Data = ram[ramIdx];
      end else begin
        case (regSel)
          selTh:      Device_Read_Data = th;
          selTl:      Device_Read_Data = tl;
          selTcon:    Device_Read_Data = {29'd0, tcon};
          selLed:     Device_Read_Data = {24'd0, leds};
          selDigits:  Device_Read_Data = {20'd0, digits};
          selSystick: Device_Read_Data = systick;
          default:    Device_Read_Data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a reference model predicts each load into a
// scoreboard queue that a negedge monitor drains and compares.
module tb_mem_bus_responder;

  localparam int unsigned RamWords = 512;
  localparam logic [31:0] RamBytes = 32'(4 * RamWords);
  localparam logic [31:0] Base     = 32'h4000_0000;
  localparam logic [31:0] AddrTh   = Base;
  localparam logic [31:0] AddrTl   = Base + 32'h04;
  localparam logic [31:0] AddrTcon = Base + 32'h08;
  localparam logic [31:0] AddrLed  = Base + 32'h0C;
  localparam logic [31:0] AddrDig  = Base + 32'h10;
  localparam logic [31:0] AddrSys  = Base + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  always #5 clk = ~clk;

  mem_bus_responder #(.RAM_WORDS(RamWords), .PERIPH_BASE(Base)) dut (
    .clk               (clk),
    .reset             (reset),
    .MemBus_Address    (addr),
    .MemBus_Write_Data (wdata),
    .MemRead           (rd),
    .MemWrite_origin   (wr),
    .Device_Read_Data  (rdata),
    .irq               (irq),
    .leds              (leds),
    .digits            (digits)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic        modelLive = 1'b0;
  logic [31:0] mTh, mTl, mSys;
  logic [2:0]  mTcon;
  logic [7:0]  mLed;
  logic [11:0] mDig;
  logic [31:0] mRam [int];

  logic [31:0] expQ [$];
  string       tagQ [$];
  logic [31:0] monExp;
  string       monTag;
  logic [31:0] scratch;

  task automatic modelReset();
    mTh = '0; mTl = '0; mTcon = '0; mLed = '0; mDig = '0; mSys = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < RamBytes) return mRam.exists(int'(w >> 2)) ? mRam[int'(w >> 2)] : 32'hx;
    case (w)
      AddrTh:   return mTh;
      AddrTl:   return mTl;
      AddrTcon: return {29'd0, mTcon};
      AddrLed:  return {24'd0, mLed};
      AddrDig:  return {20'd0, mDig};
      AddrSys:  return mSys;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic modelStep(input logic [31:0] a, input logic [31:0] d, input logic w);
    logic [31:0] wa;
    logic        hitTl, hitTcon;
    wa      = {a[31:2], 2'b00};
    hitTl   = w && (wa == AddrTl);
    hitTcon = w && (wa == AddrTcon);
    if (!(hitTl || hitTcon) && mTcon[0]) begin
      if (mTl == 32'hFFFF_FFFF) begin
        mTl = mTh;
        if (mTcon[1]) mTcon[2] = 1'b1;
      end else begin
        mTl = mTl + 1;
      end
    end
    if (w) begin
      if (wa < RamBytes) mRam[int'(wa >> 2)] = d;
      else case (wa)
        AddrTh:   mTh   = d;
        AddrTl:   mTl   = d;
        AddrTcon: mTcon = d[2:0];
        AddrLed:  mLed  = d[7:0];
        AddrDig:  mDig  = d[11:0];
        default:  ;
      endcase
    end
    mSys = mSys + 1;
  endtask

  // One bus cycle: drive, record expected load data, sample at negedge, step model at the edge.
  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, output logic [31:0] got);
    addr = a; wdata = d; rd = r; wr = w;
    if (r) begin
      expQ.push_back(modelRead(a));
      tagQ.push_back(tag);
    end
    @(negedge clk);
    got = rdata;
    @(posedge clk);
    modelStep(a, d, w);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic storeOp(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(tag, a, d, 1'b0, 1'b1, scratch);
  endtask

  task automatic loadOp(input string tag, input logic [31:0] a, output logic [31:0] got);
    drive(tag, a, 32'h0, 1'b1, 1'b0, got);
  endtask

  // Scoreboard monitor: load data and the level outputs against the model.
  always @(negedge clk) begin
    if (modelLive && !reset) begin
      if (rd) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_underflow: load at %h with no expectation", addr);
        end else begin
          monExp = expQ.pop_front();
          monTag = tagQ.pop_front();
          if (rdata !== monExp) begin
            miscompares++;
            $display("FAIL %s: read data %h, required %h", monTag, rdata, monExp);
          end
        end
      end
      vectors++;
      if ({irq, leds, digits} !== {mTcon[1] & mTcon[2], mLed, mDig}) begin
        miscompares++;
        $display("FAIL outputs: irq/leds/digits %b/%h/%h, required %b/%h/%h",
                 irq, leds, digits, mTcon[1] & mTcon[2], mLed, mDig);
      end
    end
  end

  task automatic test_reset();
    #3;
    vectors++;
    if ({irq, leds, digits} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: %b/%h/%h, required 0/00/000", irq, leds, digits);
    end
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: %h, required 00000000", rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    modelLive = 1'b1;

    storeOp("ram20", 32'h20, 32'h1111_1111);
    storeOp("led", AddrLed, 32'h3C);
    storeOp("dig", AddrDig, 32'h123);
    storeOp("th", AddrTh, 32'h2);
    storeOp("tl", AddrTl, 32'hFFFF_FFFE);
    storeOp("tcon", AddrTcon, 32'h3);
    repeat (5) loadOp("pre_reset_count", AddrTl, scratch);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_irq: %b, required 1", irq);
    end

    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({irq, leds, digits} !== '0) begin
      miscompares++;
      $display("FAIL async_clear: %b/%h/%h, required 0/00/000", irq, leds, digits);
    end
    addr = 32'h20; wdata = 32'h2222_2222; wr = 1'b1; rd = 1'b0;
    @(posedge clk);
    #1 wr = 1'b0; reset = 1'b0;
    modelReset();

    loadOp("tl_after_reset", AddrTl, scratch);
    loadOp("ram_kept_over_reset", 32'h20, scratch);
    loadOp("led_after_reset", AddrLed, scratch);
  endtask

  task automatic test_ram();
    storeOp("ram_st10", 32'h0000_0010, 32'hDEAD_BEEF);
    storeOp("ram_st7fc", 32'h0000_07FC, 32'h1234_5678);
    loadOp("ram_ld10", 32'h0000_0010, scratch);
    loadOp("ram_ld7fc", 32'h0000_07FC, scratch);
    loadOp("ram_ld800_unmapped", 32'h0000_0800, scratch);
    drive("ram_rmw_old", 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 1'b1, scratch);
    loadOp("ram_rmw_new", 32'h0000_0010, scratch);
    storeOp("ram_st0", 32'h0000_0000, 32'hA0A0_A0A0);
  endtask

  task automatic test_peripherals();
    logic [31:0] s1, s2;
    storeOp("led_st", AddrLed, 32'h1A5);
    vectors++;
    if (leds !== 8'hA5) begin
      miscompares++;
      $display("FAIL led_pin: %h, required a5", leds);
    end
    loadOp("led_ld", AddrLed, scratch);
    storeOp("dig_st", AddrDig, 32'hFFF);
    vectors++;
    if (digits !== 12'hFFF) begin
      miscompares++;
      $display("FAIL digits_pin: %h, required fff", digits);
    end
    loadOp("dig_ld", AddrDig, scratch);
    storeOp("systick_st", AddrSys, 32'h0);
    loadOp("systick_ld1", AddrSys, s1);
    loadOp("systick_ld2", AddrSys, s2);
    vectors++;
    if (s2 - s1 !== 32'd1) begin
      miscompares++;
      $display("FAIL systick_step: difference %0d, required 1", s2 - s1);
    end
  endtask

  task automatic test_timer_overflow();
    int edges;
    storeOp("tmr_th", AddrTh, 32'hFFFF_FFFD);
    storeOp("tmr_tl", AddrTl, 32'hFFFF_FFFE);
    storeOp("tmr_tcon", AddrTcon, 32'h3);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early0: %b, required 0", irq);
    end
    loadOp("tmr_tl_fe", AddrTl, scratch);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early1: %b, required 0", irq);
    end
    loadOp("tmr_tl_ff", AddrTl, scratch);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_two_edges: %b, required 1", irq);
    end
    for (int k = 0; k < 2; k++) begin
      storeOp("tmr_clear", AddrTcon, 32'h3);
      edges = 0;
      while (irq !== 1'b1 && edges < 8) begin
        loadOp("tmr_reload_tl", AddrTl, scratch);
        edges++;
      end
      vectors++;
      if (edges != 3) begin
        miscompares++;
        $display("FAIL irq_period: %0d edges after clear, required 3", edges);
      end
    end
    storeOp("tmr_off", AddrTcon, 32'h0);
  endtask

  task automatic test_priority();
    storeOp("pri_tl_ff", AddrTl, 32'hFFFF_FFFF);
    storeOp("pri_th", AddrTh, 32'h55);
    storeOp("pri_tcon", AddrTcon, 32'h3);
    storeOp("pri_tl7", AddrTl, 32'h7);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL store_beats_overflow_irq: %b, required 0", irq);
    end
    loadOp("pri_tl_is7", AddrTl, scratch);
    loadOp("pri_tcon_no_status", AddrTcon, scratch);
    storeOp("pri_tl_fe", AddrTl, 32'hFFFF_FFFE);
    loadOp("pri_tl_fe_rd", AddrTl, scratch);
    storeOp("pri_th_on_overflow", AddrTh, 32'h99);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL th_store_overflow_irq: %b, required 1", irq);
    end
    loadOp("pri_tl_old_th", AddrTl, scratch);
    loadOp("pri_th_new", AddrTh, scratch);
    storeOp("pri_tcon_010", AddrTcon, 32'h2);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_drop: %b, required 0", irq);
    end
    loadOp("pri_tl_hold1", AddrTl, scratch);
    loadOp("pri_tl_hold2", AddrTl, scratch);
  endtask

  task automatic test_gating();
    addr = AddrLed; rd = 1'b0; wr = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL read_gate: %h, required 00000000", rdata);
    end
    rd = 1'b1;
    #1;
    vectors++;
    if (rdata !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL read_ungated: %h, required 000000a5", rdata);
    end
    rd = 1'b0;
    storeOp("unmapped_5000", 32'h5000_0000, 32'hFFFF_FFFF);
    storeOp("unmapped_4018", Base + 32'h18, 32'hFFFF_FFFF);
    storeOp("unmapped_0800", 32'h0000_0800, 32'hFFFF_FFFF);
    loadOp("unm_th", AddrTh, scratch);
    loadOp("unm_tl", AddrTl, scratch);
    loadOp("unm_tcon", AddrTcon, scratch);
    loadOp("unm_led", AddrLed, scratch);
    loadOp("unm_dig", AddrDig, scratch);
    loadOp("unm_ram0", 32'h0000_0000, scratch);
    loadOp("unm_ram10", 32'h0000_0010, scratch);
    loadOp("unm_ram7fc", 32'h0000_07FC, scratch);
    loadOp("unm_rd5000", 32'h5000_0000, scratch);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0;
    test_reset();
    test_ram();
    test_peripherals();
    test_timer_overflow();
    test_priority();
    test_gating();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
